// File: rtl/rf_access_sched_pkg.sv
// rf_access_sched_pkg: shared sizes and FSM encoding for the register-group access scheduler
package rf_access_sched_pkg;
    localparam int NREG = 4;
    localparam int AW   = 2;
    localparam int DW   = 16;
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WAIT, ST_HOLD} state_t;
endpackage

// File: rtl/rf_wr_arb.sv
// rf_wr_arb: two-way round-robin write-port arbiter with one-hot write-enable decode
module rf_wr_arb #(
    parameter int NREG = rf_access_sched_pkg::NREG,
    parameter int AW   = rf_access_sched_pkg::AW,
    parameter int DW   = rf_access_sched_pkg::DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_a_valid,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic            i_b_valid,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    output logic            o_a_gnt,
    output logic            o_b_gnt,
    output logic            o_gnt,
    output logic [AW-1:0]   o_addr,
    output logic [NREG-1:0] o_reg_en,
    output logic [DW-1:0]   o_data
);
    logic r_prio_b;
    logic w_contend;
    // r_prio_b is set when A won the last contended cycle, so B goes first next time
    always_comb begin
        w_contend = i_a_valid & i_b_valid;
        o_a_gnt   = i_a_valid & (~i_b_valid | ~r_prio_b);
        o_b_gnt   = i_b_valid & ~o_a_gnt;
        o_gnt     = o_a_gnt | o_b_gnt;
        o_addr    = o_a_gnt ? i_a_addr : i_b_addr;
        o_reg_en  = o_a_gnt ? NREG'(1) << i_a_addr : o_b_gnt ? NREG'(1) << i_b_addr : '0;
        o_data    = o_a_gnt ? i_a_data : o_b_gnt ? i_b_data : '0;
    end
    always_ff @(posedge clk) begin
        if (rst)
            r_prio_b <= 1'b0;
        else if (w_contend)
            r_prio_b <= o_a_gnt;
    end
endmodule

// File: rtl/rf_access_sched.sv
// rf_access_sched: operand-read sequencer with pending scoreboard in front of the 4x16 register group;
// write-backs from ALU and memory share the single write port through rf_wr_arb.
module rf_access_sched
    import rf_access_sched_pkg::*;
#(
    parameter int NREG = rf_access_sched_pkg::NREG,
    parameter int AW   = rf_access_sched_pkg::AW,
    parameter int DW   = rf_access_sched_pkg::DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rq_valid,
    output logic            rq_ready,
    input  logic [AW-1:0]   rq_rd,
    input  logic [AW-1:0]   rq_rs,
    input  logic            rq_wb,
    input  logic [AW-1:0]   rq_wb_addr,
    input  logic            alu_wr_valid,
    input  logic [AW-1:0]   alu_wr_addr,
    input  logic [DW-1:0]   alu_wr_data,
    output logic            alu_wr_ready,
    input  logic            mem_wr_valid,
    input  logic [AW-1:0]   mem_wr_addr,
    input  logic [DW-1:0]   mem_wr_data,
    output logic            mem_wr_ready,
    output logic            rf_en_in,
    output logic [AW-1:0]   rf_rd,
    output logic [AW-1:0]   rf_rs,
    output logic [NREG-1:0] rf_reg_en,
    output logic [DW-1:0]   rf_d_in,
    input  logic            rf_en_out,
    input  logic [DW-1:0]   rf_rd_q,
    input  logic [DW-1:0]   rf_rs_q,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [DW-1:0]   op_a,
    output logic [DW-1:0]   op_b,
    output logic [NREG-1:0] sb_pending,
    output logic            sb_err
);
    state_t          r_state, w_next;
    logic [AW-1:0]   r_rd, r_rs;
    logic [DW-1:0]   r_op_a, r_op_b;
    logic [NREG-1:0] r_pend, w_set;
    logic            r_err;
    logic            w_gnt, w_hazard, w_accept;
    logic [AW-1:0]   w_gaddr;

    rf_wr_arb #(.NREG(NREG), .AW(AW), .DW(DW)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_a_valid(alu_wr_valid),
        .i_a_addr (alu_wr_addr),
        .i_a_data (alu_wr_data),
        .i_b_valid(mem_wr_valid),
        .i_b_addr (mem_wr_addr),
        .i_b_data (mem_wr_data),
        .o_a_gnt  (alu_wr_ready),
        .o_b_gnt  (mem_wr_ready),
        .o_gnt    (w_gnt),
        .o_addr   (w_gaddr),
        .o_reg_en (rf_reg_en),
        .o_data   (rf_d_in)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == ST_IDLE) ? (w_accept ? ST_READ : ST_IDLE) :
                 (r_state == ST_READ) ? ST_WAIT :
                 (r_state == ST_WAIT) ? (rf_en_out ? ST_HOLD : ST_WAIT) :
                                        (op_ready ? ST_IDLE : ST_HOLD);
    end

    // a grant to a source register this cycle would race the read, so hold off one cycle
    always_comb begin
        w_hazard = w_gnt & ((w_gaddr == rq_rd) | (w_gaddr == rq_rs));
        rq_ready = (r_state == ST_IDLE) & ~r_pend[rq_rd] & ~r_pend[rq_rs] & ~w_hazard;
        w_accept = rq_valid & rq_ready;
        rf_en_in = (r_state == ST_READ);
        op_valid = (r_state == ST_HOLD);
        w_set    = (w_accept & rq_wb) ? NREG'(1) << rq_wb_addr : '0;
    end

    // clear then set, so a new claim outlives a same-edge write-back to that register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_err  <= 1'b0;
            r_rd   <= '0;
            r_rs   <= '0;
            r_op_a <= '0;
            r_op_b <= '0;
        end else begin
            r_pend <= (r_pend & ~rf_reg_en) | w_set;
            r_err  <= r_err | (w_gnt & ~r_pend[w_gaddr]);
            if (w_accept) begin
                r_rd <= rq_rd;
                r_rs <= rq_rs;
            end
            if (r_state == ST_WAIT && rf_en_out) begin
                r_op_a <= rf_rd_q;
                r_op_b <= rf_rs_q;
            end
        end
    end

    assign rf_rd      = r_rd;
    assign rf_rs      = r_rs;
    assign op_a       = r_op_a;
    assign op_b       = r_op_b;
    assign sb_pending = r_pend;
    assign sb_err     = r_err;
endmodule

// File: doc/rf_access_sched.md
Name: rf_access_sched

Overview:
Scheduler in front of the 4x16 register group. It accepts operand-read requests from decode and write-back requests from two producers (ALU and memory). It arbitrates the single register-group write port round-robin and keeps a per-register pending scoreboard so reads never see stale data. It drives the register group's read strobe, addresses and one-hot write enables, then holds the returned operands until the execute stage accepts them.

Parameters:
NREG, 4, number of architectural registers (one-hot write-enable width)
AW, 2, register address width (log2 NREG)
DW, 16, data width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rq_valid  in  1  decode read request valid
rq_ready  out  1  request accepted this cycle when high with rq_valid
rq_rd  in  AW  first operand register
rq_rs  in  AW  second operand register
rq_wb  in  1  request's instruction will write back
rq_wb_addr  in  AW  destination register to claim
alu_wr_valid / mem_wr_valid  in  1 each  write-back request
alu_wr_addr / mem_wr_addr  in  AW each  write-back destination
alu_wr_data / mem_wr_data  in  DW each  write-back data
alu_wr_ready / mem_wr_ready  out  1 each  write granted this cycle (combinational)
rf_en_in  out  1  read strobe to register group
rf_rd / rf_rs  out  AW each  read addresses to register group
rf_reg_en  out  NREG  one-hot write enable to register group
rf_d_in  out  DW  write data to register group
rf_en_out  in  1  register group read-done
rf_rd_q / rf_rs_q  in  DW each  register group read data
op_valid  out  1  operands valid to execute
op_ready  in  1  execute accepts operands
op_a / op_b  out  DW each  held operands
sb_pending  out  NREG  scoreboard, debug
sb_err  out  1  sticky: write-back to a non-pending register

Behaviour:
- Reset (rst high at a clk edge): state IDLE; scoreboard 0; RR pointer favours ALU; op_valid, rf_en_in, sb_err 0; op_a/op_b 0; rf_rd/rf_rs 0.
- Write arbitration is combinational each cycle. One valid requester is granted. If both are valid, the one not granted last is granted. The pointer toggles only on a contended grant.
- On a grant: rf_reg_en = one-hot(addr) and rf_d_in = data. With no grant, rf_reg_en = 0 and rf_d_in = 0.
- The register group writes at the clock edge ending the grant cycle.
- Scoreboard clear: the granted address's bit is cleared at the grant edge.
- Write to a clear bit: the write is still performed and sb_err is set (sticky until rst).
- FSM states: IDLE, READ, WAIT, HOLD.
- IDLE: rq_ready = 1 iff rq_rd and rq_rs are both not pending and no write grant this cycle targets rq_rd or rq_rs. This rule prevents a same-edge read/write race.
- IDLE accept: latch the addresses. If rq_wb, set the pending bit for rq_wb_addr. Go to READ.
- READ: rf_en_in = 1 for exactly one cycle with the latched rf_rd/rf_rs. Go to WAIT.
- WAIT: on rf_en_out = 1, capture rf_rd_q/rf_rs_q into op_a/op_b, set op_valid, go to HOLD.
- HOLD: op_a/op_b are stable while op_valid and not op_ready. On op_ready, clear op_valid and return to IDLE.
- Throughput: one read per 4 cycles minimum. Accept-to-op_valid latency is 3 cycles.
- rq_ready is 0 in every state except IDLE.
- Same-edge claim and clear of one bit: set wins (the new claim dominates the older write-back).
- Write-backs continue in every FSM state.
- rst mid-operation (any state) aborts the operation. All state returns to reset values on that edge, and outputs are driven to their reset values in the cycle after.

Decomposition:
- Shared package holds the FSM state encoding (IDLE/READ/WAIT/HOLD) and the NREG/AW/DW defaults.
- One sub-module, rf_wr_arb: the two-way round-robin write arbiter with one-hot enable decode.
- Scoreboard and FSM stay in rf_access_sched.

Test Plan:
- Reset, then ALU writes 0x1234 to r2 (r2 not pending) -> rf_reg_en=4'b0100, rf_d_in=0x1234 in that cycle; sb_err=1 afterwards.
- Read rd=1, rs=3 with no hazards, op_ready tied 1 -> accept at cycle T, rf_en_in=1 at T+1; op_valid=1 at T+3 with op_a=R1, op_b=R3.
- Claim r0 (rq_wb=1, rq_wb_addr=0), then request a read of rs=0 -> rq_ready=0 until MEM writes 0xBEEF to r0; next cycle accepted; op_b=0xBEEF.
- ALU and MEM both valid for 3 consecutive cycles -> grants alternate ALU, MEM, ALU; alu_wr_ready and mem_wr_ready are never both high.
- Hold op_ready=0 for 5 cycles in HOLD -> op_a/op_b unchanged; rq_ready=0 throughout.
- Assert rst in WAIT -> next cycle op_valid=0, sb_pending=0, rf_en_in=0; a fresh request is accepted.
